dff_ram_2p: RTL
===============

// Module: dff_ram_2p
// PURPOSE
//  Parametrised flip-flop RAM: one write port, one read port, per-byte write enables, registered read.
//  Successor to the fixed 4x72 single-port DFF RAM.
//  Adds a hardware clear sequence after reset, so contents are known (all zero) before first use.
//  Adds write-first bypass on same-address read/write collisions.
//  Used as a small buffer or register-file macro beside datapath blocks in the ASIC flow.
// PARAMETERS
//  WIDTH   72  data width in bits; must be a multiple of 8; NBYTES = WIDTH/8
//  DEPTH   4   number of words; >= 2; need not be a power of two
//  ADDR_W  $clog2(DEPTH)  address width (localparam, derived)
// PORTS
//  clk      in   1       single clock, all logic on rising edge
//  rst_n    in   1       synchronous, active-low reset
//  busy     out  1       1 while the post-reset clear sequence runs; all requests ignored
//  wr_en_n  in   1       active-low write request
//  wr_addr  in   ADDR_W  write word address
//  wr_be    in   NBYTES  byte-lane write enables; bit i covers wr_data[8i+7:8i]
//  wr_data  in   WIDTH   write data
//  rd_en_n  in   1       active-low read request
//  rd_addr  in   ADDR_W  read word address
//  rd_data  out  WIDTH   registered read data
//  rd_valid out  1       1 for one cycle when rd_data holds the result of a read
// BEHAVIOUR
//  Reset (rst_n low at a clk edge):
//   - rd_data=0, rd_valid=0, busy=1, FSM=INIT, init pointer=0.
//   - Memory array is not touched by reset itself.
//  INIT:
//   - Each cycle with rst_n high, write 0 to mem[ptr], then ptr++.
//   - After the write to DEPTH-1, FSM goes to RUN and busy falls at that same edge.
//   - busy is high for exactly DEPTH cycles after rst_n is sampled high.
//   - wr_en_n/rd_en_n are ignored in INIT; rd_valid stays 0.
//  RUN, write:
//   - wr_en_n=0 at an edge: for each i with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i.
//   - Other lanes are unchanged. wr_be=0 is a legal no-op.
//  RUN, read:
//   - rd_en_n=0 at edge N: rd_data = mem[rd_addr] and rd_valid=1 after edge N (1-cycle latency).
//   - rd_en_n=1: rd_valid=0 next cycle and rd_data holds its last value.
//  Collision (both enables low, rd_addr==wr_addr):
//   - Write-first: rd_data = merged word (new bytes where wr_be=1, old bytes elsewhere).
//   - Memory is updated at the same edge.
//  Out-of-range address (>= DEPTH, only possible when DEPTH is not a power of two):
//   - Write is dropped.
//   - Read returns all zeros with rd_valid=1.
//  Back-to-back:
//   - Reads and writes may issue every cycle with no bubbles.
//  Reset mid-operation:
//   - An in-flight read is discarded (rd_valid=0).
//   - FSM restarts INIT and the array is re-cleared.
// STRUCTURE
//  Shared package dff_ram_pkg holds:
//   - FSM state encoding (ST_INIT, ST_RUN).
//   - Byte-lane constant BYTE_W=8.
//   - Function for the byte-merge of old/new words under a mask.
//  Sub-module dff_ram_init_ctrl holds:
//   - INIT/RUN FSM, clear pointer, busy output.
//   - Clear-write strobe/address, muxed ahead of the user write port.
//  Top holds:
//   - Array as a reg vector; write decode with per-lane enables.
//   - Read mux, collision bypass, rd_data/rd_valid registers.
// TESTING  (WIDTH=72, DEPTH=4 unless stated)
//  1 Init: rst_n=0 for 2 cycles, release.
//    -> busy=1 for exactly 4 cycles then 0; reads of addr 0..3 return 72'h0 with rd_valid pulses.
//  2 Basic R/W: write 72'hA5_0123_4567_89AB_CDEF to addr 2 (wr_be=9'h1FF), read addr 2 next cycle.
//    -> same value one cycle later, rd_valid high for one cycle only.
//  3 Byte mask: addr 1 <= 72'h11_2233_4455_6677_8899, then write 72'hFF..FF with wr_be=9'h101, read.
//    -> 72'hFF_2233_4455_6677_88FF.
//  4 Collision: addr 3 holds 0; same cycle write 72'hCAFE with wr_be=9'h003 and read addr 3.
//    -> rd_data=72'h0000_0000_0000_0000_CAFE next cycle; later read also gives CAFE.
//  5 Busy/reset: write and read requested during INIT; assert rst_n=0 one cycle mid-RUN after writes.
//    -> INIT requests ignored; after reset, busy again for 4 cycles and all words read 0.
//  6 DEPTH=6: write 72'h1 to addr 7, read addr 7, read addr 5.
//    -> addr 7 read gives 0 with rd_valid=1; addr 5 unchanged (0).

Source files
------------

// File: rtl/dff_ram_pkg.sv
// Shared definitions for the two-port flip-flop RAM: FSM encoding, lane width
// and the byte-lane merge used by both the write path and the read bypass.
package dff_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One lane of an old/new word merge: the lane's mask bit picks the new byte.
  function automatic logic [BYTE_W-1:0] byte_merge(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              lane_en
  );
    return lane_en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dff_ram_init_ctrl.sv
// Post-reset clear sequencer: walks every word once writing zero, holding busy
// high until the last word has been cleared.
module dff_ram_init_ctrl
  import dff_ram_pkg::*;
#(
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    busy       = 1'b0;
    clr_we     = 1'b0;
    case (state_reg)
      ST_INIT: begin
        busy   = 1'b1;
        // No clear write on an edge where reset is still asserted.
        clr_we = rst_n;
        if (ptr_reg == LAST_ADDR) begin
          state_next = ST_RUN;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      ST_RUN: begin
        busy = 1'b0;
      end
    endcase
  end

  assign clr_addr = ptr_reg;

endmodule

// File: rtl/dff_ram_2p.sv
// Two-port flip-flop RAM: byte-enabled write port, registered read port with
// write-first bypass on address collisions, and a hardware clear after reset.
module dff_ram_2p
  import dff_ram_pkg::*;
#(
  parameter  int WIDTH  = 72,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NBYTES = WIDTH / BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  input  logic              wr_en_n,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NBYTES-1:0] wr_be,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid
);

  logic [WIDTH-1:0]  mem_reg [DEPTH];
  logic [WIDTH-1:0]  rd_data_reg;
  logic              rd_valid_reg;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_in_range, rd_in_range;
  logic              user_we, rd_req, collision;
  logic [WIDTH-1:0]  wr_old, wr_merged, rd_next;

  dff_ram_init_ctrl #(
    .DEPTH(DEPTH)
  ) u_init_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // Range checks only exist when DEPTH leaves unused address codes.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_npow2
      localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH);
      assign wr_in_range = ({1'b0, wr_addr} < ADDR_LIMIT);
      assign rd_in_range = ({1'b0, rd_addr} < ADDR_LIMIT);
    end
  endgenerate

  assign user_we   = rst_n && !busy && !wr_en_n && wr_in_range;
  assign rd_req    = !busy && !rd_en_n;
  assign collision = user_we && (rd_addr == wr_addr);

  assign wr_old = wr_in_range ? mem_reg[wr_addr] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign wr_merged[gi*BYTE_W +: BYTE_W] =
        byte_merge(wr_old[gi*BYTE_W +: BYTE_W], wr_data[gi*BYTE_W +: BYTE_W], wr_be[gi]);
    end
  endgenerate

  // Clear writes and user writes never overlap: one needs busy, the other !busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_reg[clr_addr] <= '0;
    end else if (user_we) begin
      mem_reg[wr_addr] <= wr_merged;
    end
  end

  always_comb begin
    rd_next = '0;
    if (collision) begin
      rd_next = wr_merged;
    end else if (rd_in_range) begin
      rd_next = mem_reg[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_req;
      if (rd_req) begin
        rd_data_reg <= rd_next;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule
